// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared MDU issue definitions: op and move-to codes, FSM states, default latencies.
package mdu_issue_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_MULTU = 4'd0,
    OP_MULT  = 4'd1,
    OP_DIVU  = 4'd2,
    OP_DIV   = 4'd3,
    OP_MADDU = 4'd4,
    OP_MADD  = 4'd5,
    OP_MSUBU = 4'd6,
    OP_MSUB  = 4'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    MT_NONE = 2'b00,
    MT_LO   = 2'b01,
    MT_HI   = 2'b11
  } mt_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DEF_MULT_LAT = 5;
  localparam int DEF_DIV_LAT  = 10;

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  function automatic logic is_mt(input logic [1:0] mt);
    return (mt == MT_LO) || (mt == MT_HI);
  endfunction

endpackage

// File: rtl/mdu_issue_ctrl_lat_counter.sv
// Latency down-counter: clear beats load beats decrement; saturates at zero.
module mdu_issue_ctrl_lat_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] cnt,
  output logic       is_zero,
  output logic       is_one
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (clear) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !is_zero) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign is_zero = (cnt == 4'd0);
  assign is_one  = (cnt == 4'd1);

endmodule

// File: rtl/mdu_issue_ctrl.sv
// E-stage MDU issue controller: start pulses, latency tracking, stall and HI/LO commit pulse.
// Optional MDU_PERF_CNT_EN adds issued-op and stall-cycle counters (tied to 0 otherwise).
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [1:0]  req_mt,
  input  logic        req_mf,
  input  logic        flush,
  output logic        start,
  output logic [3:0]  start_op,
  output logic [1:0]  mt_en,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [3:0]  cnt,
  output logic [31:0] perf_ops,
  output logic [31:0] perf_stall
);

  state_e     state;
  logic       run;
  logic       op_req;
  logic       mt_req;
  logic       issue;
  logic       cnt_zero;
  logic       cnt_one;
  logic [3:0] lat_val;

  assign run    = (state == ST_RUN);
  assign op_req = req_valid && !req_op[3];
  assign mt_req = req_valid && is_mt(req_mt);

  // A read of HI/LO in the commit cycle takes one bubble so it sees the new value.
  assign stall = !reset &&
                 ((run && (op_req || mt_req || (req_valid && req_mf))) || (req_mf && done));

  assign issue    = !reset && !flush && !run && op_req && !stall;
  assign start    = issue;
  assign start_op = issue ? req_op : 4'd0;
  assign mt_en    = (!reset && !flush && !run && !op_req && mt_req && !stall) ? req_mt : 2'b00;

  assign lat_val = is_div(req_op) ? 4'(DIV_LAT) : 4'(MULT_LAT);

  mdu_issue_ctrl_lat_counter u_lat (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .load     (issue),
    .load_val (lat_val),
    .dec      (run && !cnt_zero),
    .cnt      (cnt),
    .is_zero  (cnt_zero),
    .is_one   (cnt_one)
  );

  // Flush suppresses the commit even when it lands on the final count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else if (run) begin
        if (cnt_one) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end else if (issue) begin
        state <= ST_RUN;
        busy  <= 1'b1;
      end
    end
  end

`ifdef MDU_PERF_CNT_EN
  logic [31:0] ops_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ops_q   <= 32'd0;
      stall_q <= 32'd0;
    end else begin
      if (start) ops_q <= ops_q + 32'd1;
      if (stall) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_ops   = ops_q;
  assign perf_stall = stall_q;
`else
  assign perf_ops   = 32'd0;
  assign perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Scenario bench for mdu_issue_ctrl; expected commit cycles are queued at issue and matched on done.
module tb_mdu_issue_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [3:0]  req_op = 4'd8;
  logic [1:0]  req_mt = 2'b00;
  logic        req_mf = 1'b0;
  logic        flush = 1'b0;
  logic        start;
  logic [3:0]  start_op;
  logic [1:0]  mt_en;
  logic        busy;
  logic        stall;
  logic        done;
  logic [3:0]  cnt;
  logic [31:0] perf_ops;
  logic [31:0] perf_stall;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_q[$];

  mdu_issue_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_mt     (req_mt),
    .req_mf     (req_mf),
    .flush      (flush),
    .start      (start),
    .start_op   (start_op),
    .mt_en      (mt_en),
    .busy       (busy),
    .stall      (stall),
    .done       (done),
    .cnt        (cnt),
    .perf_ops   (perf_ops),
    .perf_stall (perf_stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every done pulse must match the oldest expected commit cycle.
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_spurious cyc=%0d got done=1 want no commit", cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (cyc !== e) begin
          errors++;
          $display("FAIL done_cycle got cyc=%0d want %0d", cyc, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_req();
    req_valid = 1'b0; req_op = 4'd8; req_mt = 2'b00; req_mf = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    req_valid = 1'b1; req_op = 4'd1; req_mt = 2'b11; req_mf = 1'b1;
    nxt(); nxt();
    #1;
    checks++;
    if (start !== 1'b0 || start_op !== 4'd0 || mt_en !== 2'b00 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_comb got start=%b op=%0d mt_en=%b stall=%b want 0/0/00/0",
               start, start_op, mt_en, stall);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_regs got busy=%b done=%b cnt=%0d want 0/0/0", busy, done, cnt);
    end
    idle_req();
    nxt();
    reset = 1'b0;
  endtask

  task automatic test_mult();
    int c0;
    int ec;
    nxt(); req_valid = 1'b1; req_op = 4'd1; #1;
    c0 = cyc;
    checks++;
    if (start !== 1'b1 || start_op !== 4'd1) begin
      errors++;
      $display("FAIL mult_start got start=%b op=%0d want 1/1", start, start_op);
    end
    exp_q.push_back(c0 + MULT_LAT + 1);
    for (int i = 1; i <= MULT_LAT + 3; i++) begin
      nxt(); idle_req(); #1;
      ec = (i <= MULT_LAT) ? (MULT_LAT + 1 - i) : 0;
      checks++;
      if (busy !== (i <= MULT_LAT) || cnt !== 4'(ec)) begin
        errors++;
        $display("FAIL mult_seq i=%0d got busy=%b cnt=%0d want %b/%0d", i, busy, cnt, (i <= MULT_LAT), ec);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL mult_drain got %0d pending want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_div_mf();
    logic es;
    nxt(); req_valid = 1'b1; req_op = 4'd3; #1;
    checks++;
    if (start !== 1'b1 || start_op !== 4'd3) begin
      errors++;
      $display("FAIL div_start got start=%b op=%0d want 1/3", start, start_op);
    end
    exp_q.push_back(cyc + DIV_LAT + 1);
    for (int i = 1; i <= DIV_LAT + 2; i++) begin
      nxt();
      if (i == 1) idle_req();
      else begin req_valid = 1'b1; req_op = 4'd8; req_mf = 1'b1; end
      #1;
      es = (i >= 2 && i <= DIV_LAT + 1);
      checks++;
      if (stall !== es) begin
        errors++;
        $display("FAIL div_mf_stall i=%0d got stall=%b want %b", i, stall, es);
      end
    end
    nxt(); idle_req();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL div_drain got %0d pending want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_mt();
    logic er;
    nxt(); req_valid = 1'b1; req_op = 4'd8; req_mt = 2'b11; #1;
    checks++;
    if (mt_en !== 2'b11 || stall !== 1'b0 || start !== 1'b0) begin
      errors++;
      $display("FAIL mthi_idle got mt_en=%b stall=%b start=%b want 11/0/0", mt_en, stall, start);
    end
    nxt(); req_op = 4'd1; req_mt = 2'b11; #1;
    checks++;
    if (start !== 1'b1 || mt_en !== 2'b00) begin
      errors++;
      $display("FAIL op_wins got start=%b mt_en=%b want 1/00", start, mt_en);
    end
    exp_q.push_back(cyc + MULT_LAT + 1);
    for (int i = 1; i <= MULT_LAT + 1; i++) begin
      nxt(); req_valid = 1'b1; req_op = 4'd8; req_mt = 2'b01; #1;
      er = (i <= MULT_LAT);
      checks++;
      if (stall !== er || mt_en !== (er ? 2'b00 : 2'b01)) begin
        errors++;
        $display("FAIL mtlo_run i=%0d got stall=%b mt_en=%b want %b/%b", i, stall, mt_en, er, (er ? 2'b00 : 2'b01));
      end
    end
    nxt(); idle_req();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL mt_drain got %0d pending want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_flush();
    nxt(); req_valid = 1'b1; req_op = 4'd2; #1;
    checks++;
    if (start !== 1'b1 || start_op !== 4'd2) begin
      errors++;
      $display("FAIL divu_start got start=%b op=%0d want 1/2", start, start_op);
    end
    for (int i = 1; i <= DIV_LAT + 4; i++) begin
      nxt(); idle_req(); flush = (i == 4); #1;
      if (i == 5) begin
        checks++;
        if (busy !== 1'b0 || cnt !== 4'd0) begin
          errors++;
          $display("FAIL flush_run got busy=%b cnt=%0d want 0/0", busy, cnt);
        end
      end
    end
    nxt(); req_valid = 1'b1; req_op = 4'd1; #1;
    for (int i = 1; i <= MULT_LAT + 3; i++) begin
      nxt(); idle_req(); flush = (i == MULT_LAT); #1;
      if (i == MULT_LAT) begin
        checks++;
        if (cnt !== 4'd1) begin
          errors++;
          $display("FAIL flush_last_cnt got cnt=%0d want 1", cnt);
        end
      end
      if (i == MULT_LAT + 1) begin
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL flush_last got busy=%b done=%b want 0/0", busy, done);
        end
      end
    end
    nxt(); req_valid = 1'b1; req_op = 4'd1; flush = 1'b1; #1;
    checks++;
    if (start !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_op got start=%b want 0", start);
    end
    req_op = 4'd8; req_mt = 2'b11; #1;
    checks++;
    if (mt_en !== 2'b00) begin
      errors++;
      $display("FAIL flush_idle_mt got mt_en=%b want 00", mt_en);
    end
    nxt(); idle_req(); #1;
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL flush_after got busy=%b pending=%0d want 0/0", busy, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    nxt(); req_valid = 1'b1; req_op = 4'd1; #1;
    exp_q.push_back(cyc + MULT_LAT + 1);
    for (int i = 1; i <= MULT_LAT; i++) begin
      nxt(); req_valid = 1'b1; req_op = 4'd9; #1;
      checks++;
      if (stall !== 1'b0 || start !== 1'b0) begin
        errors++;
        $display("FAIL nop_run i=%0d got stall=%b start=%b want 0/0", i, stall, start);
      end
    end
    nxt(); req_valid = 1'b1; req_op = 4'd5; #1;
    checks++;
    if (done !== 1'b1 || start !== 1'b1 || stall !== 1'b0 || start_op !== 4'd5) begin
      errors++;
      $display("FAIL b2b_issue got done=%b start=%b stall=%b op=%0d want 1/1/0/5", done, start, stall, start_op);
    end
    exp_q.push_back(cyc + MULT_LAT + 1);
    for (int i = 1; i <= MULT_LAT + 2; i++) begin
      nxt(); idle_req(); #1;
      if (i == 1) begin
        checks++;
        if (cnt !== 4'(MULT_LAT) || busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_load got cnt=%0d busy=%b want %0d/1", cnt, busy, MULT_LAT);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain got %0d pending want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_async_reset();
    nxt(); req_valid = 1'b1; req_op = 4'd1; #1;
    exp_q.push_back(cyc + MULT_LAT + 1);
    nxt(); idle_req();
    nxt();
    #2; reset = 1'b1; exp_q.delete();
    #1;
    checks++;
    if (busy !== 1'b0 || cnt !== 4'd0) begin
      errors++;
      $display("FAIL async_reset got busy=%b cnt=%0d want 0/0", busy, cnt);
    end
    nxt(); reset = 1'b0;
    for (int i = 0; i < MULT_LAT + 3; i++) nxt();
    nxt(); req_valid = 1'b1; req_op = 4'd0; #1;
    checks++;
    if (start !== 1'b1 || start_op !== 4'd0) begin
      errors++;
      $display("FAIL post_reset_start got start=%b op=%0d want 1/0", start, start_op);
    end
    exp_q.push_back(cyc + MULT_LAT + 1);
    for (int i = 0; i < MULT_LAT + 2; i++) begin nxt(); idle_req(); end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL post_reset_drain got %0d pending want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_perf();
    int eo;
    int es;
    nxt(); reset = 1'b1;
    nxt(); reset = 1'b0;
    nxt(); req_valid = 1'b1; req_op = 4'd1; #1;
    exp_q.push_back(cyc + MULT_LAT + 1);
    for (int i = 1; i <= MULT_LAT + 2; i++) begin
      nxt(); req_valid = 1'b1; req_op = 4'd8; req_mf = 1'b1; #1;
      checks++;
      if (stall !== (i <= MULT_LAT + 1)) begin
        errors++;
        $display("FAIL mfhi_wait i=%0d got stall=%b want %b", i, stall, (i <= MULT_LAT + 1));
      end
    end
    for (int k = 0; k < 2; k++) begin
      nxt(); req_valid = 1'b1; req_op = 4'd4; req_mf = 1'b0; #1;
      exp_q.push_back(cyc + MULT_LAT + 1);
      for (int i = 0; i < MULT_LAT + 2; i++) begin nxt(); idle_req(); end
    end
    #1;
`ifdef MDU_PERF_CNT_EN
    eo = 3; es = MULT_LAT + 1;
`else
    eo = 0; es = 0;
`endif
    checks++;
    if (perf_ops !== 32'(eo) || perf_stall !== 32'(es)) begin
      errors++;
      $display("FAIL perf got ops=%0d stall=%0d want %0d/%0d", perf_ops, perf_stall, eo, es);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL perf_drain got %0d pending want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div_mf();
    test_mt();
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_perf();
    nxt(); nxt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
